// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master between N_REQ requesters; latency: grant 1 cycle after req, start_trans 3 cycles after req.
// Backpressure: requesters hold req until done; no new grant while the master reports busy. Optional watchdog: SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter #(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_tx_data,
    input  logic [2*N_REQ-1:0]   req_len,
    input  logic [2*N_REQ-1:0]   req_mode,
    input  logic [4*N_REQ-1:0]   req_div,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [31:0]          rx_out,
    output logic                 err,
    output logic [N_REQ-1:0]     cs_sel,
    output logic                 start_trans,
    input  logic                 busy,
    output logic [31:0]          tx_data,
    input  logic [31:0]          rx_data,
    output logic [1:0]           transaction_length,
    output logic                 CPOL,
    output logic                 CPHA,
    output logic [3:0]           division_ratio
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      win;
    logic [PW-1:0]      cand;
    logic               win_vld;
    logic               setup_cnt;
    logic [N_REQ-1:0]   grant_q;
    logic               to_hit;

    // Scan downward so the last hit kept is the nearest requester after ptr.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = PW'((int'(ptr) + i) % N_REQ);
            if (req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state_nxt == S_SETUP) begin
            to_cnt <= '0;
        end else if (state == S_START || state == S_WAIT) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_hit = (state == S_START || state == S_WAIT) &&
                    (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    wire unused_timeout = (TIMEOUT_CYCLES != 0);
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!busy && win_vld) state_nxt = S_SETUP;
            S_SETUP: if (setup_cnt)        state_nxt = S_START;
            S_START: begin
                if (to_hit)    state_nxt = S_IDLE;
                else if (busy) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (to_hit)     state_nxt = S_IDLE;
                else if (!busy) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            ptr                <= PW'(N_REQ - 1);
            setup_cnt          <= 1'b0;
            grant_q            <= '0;
            rx_out             <= '0;
            tx_data            <= '0;
            transaction_length <= '0;
            CPOL               <= 1'b0;
            CPHA               <= 1'b0;
            division_ratio     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (!busy && win_vld) begin
                        grant_q            <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                        ptr                <= win;
                        setup_cnt          <= 1'b0;
                        tx_data            <= req_tx_data[32*win +: 32];
                        transaction_length <= req_len[2*win +: 2];
                        {CPOL, CPHA}       <= req_mode[2*win +: 2];
                        division_ratio     <= req_div[4*win +: 4];
                    end
                end
                S_SETUP: setup_cnt <= 1'b1;
                S_START: if (to_hit) grant_q <= '0;
                S_WAIT: begin
                    if (to_hit)     grant_q <= '0;
                    else if (!busy) rx_out  <= rx_data;
                end
                S_DONE:  grant_q <= '0;
                default: grant_q <= '0;
            endcase
        end
    end

    assign grant       = grant_q;
    assign cs_sel      = grant_q;
    assign start_trans = (state == S_START);
    assign done        = (state == S_DONE || to_hit) ? grant_q : '0;
    assign err         = to_hit;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a small echoing SPI master model.
module tb_spi_master_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [63:0] req_tx_data = {32'h3C3C0F0F, 32'hA5A5A5A5};
    logic [3:0]  req_len  = {2'd1, 2'd0};
    logic [3:0]  req_mode = {2'b11, 2'b00};
    logic [7:0]  req_div  = {4'd5, 4'd3};
    logic [1:0]  grant, done, cs_sel;
    logic [31:0] rx_out, tx_data;
    logic [31:0] rx_data = '0;
    logic        err, start_trans, busy;
    logic [1:0]  transaction_length;
    logic        CPOL, CPHA;
    logic [3:0]  division_ratio;

    logic        m_busy = 1'b0;
    logic        busy_hold = 1'b0;
    logic        model_en = 1'b1;
    int          m_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic        seen;
    logic [1:0]  exp_g [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

    assign busy = m_busy | busy_hold;

    spi_master_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_tx_data(req_tx_data),
        .req_len(req_len), .req_mode(req_mode), .req_div(req_div),
        .grant(grant), .done(done), .rx_out(rx_out), .err(err),
        .cs_sel(cs_sel), .start_trans(start_trans), .busy(busy),
        .tx_data(tx_data), .rx_data(rx_data),
        .transaction_length(transaction_length), .CPOL(CPOL), .CPHA(CPHA),
        .division_ratio(division_ratio)
    );

    always #5 clk = ~clk;

    // Master: busy 4 cycles after seeing start_trans, then returns the tx word.
    always @(negedge clk) begin
        if (m_cnt != 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_busy  = 1'b0;
                rx_data = tx_data;
            end
        end else if (model_en && start_trans && !m_busy) begin
            m_busy = 1'b1;
            m_cnt  = 4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = (grant != 2'b00);
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = (done != 2'b00);
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, {30'd0, grant}, 32'd0);
        chk({tag, "_done"},  {30'd0, done}, 32'd0);
        chk({tag, "_cs"},    {30'd0, cs_sel}, 32'd0);
        chk({tag, "_start_err"}, {30'd0, start_trans, err}, 32'd0);
        chk({tag, "_rx_out"},  rx_out, 32'd0);
        chk({tag, "_tx_data"}, tx_data, 32'd0);
        chk({tag, "_cfg"}, {24'd0, CPOL, CPHA, transaction_length, division_ratio}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single transaction from requester 0.
        req = 2'b01;
        tick();
        chk("t1_grant", {30'd0, grant}, 32'h1);
        chk("t1_cs", {30'd0, cs_sel}, 32'h1);
        chk("t1_tx", tx_data, 32'hA5A5A5A5);
        chk("t1_div", {28'd0, division_ratio}, 32'd3);
        chk("t1_start_setup", {31'd0, start_trans}, 32'd0);
        tick();
        chk("t1_start_setup2", {31'd0, start_trans}, 32'd0);
        tick();
        chk("t1_start_rise", {31'd0, start_trans}, 32'd1);
        wait_done("t1_done_seen");
        chk("t1_done", {30'd0, done}, 32'h1);
        chk("t1_rx", rx_out, 32'hA5A5A5A5);
        chk("t1_err", {31'd0, err}, 32'd0);
        req = 2'b00;
        tick();
        chk("t1_done_pulse", {30'd0, done}, 32'd0);
        chk("t1_release", {30'd0, grant}, 32'd0);

        // Both requesting: strict alternation with one idle cycle between.
        req = 2'b11;
        wait_grant("t2_first_grant");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_grant%0d", i), {30'd0, grant}, {30'd0, exp_g[i]});
            chk($sformatf("t2_cfg%0d", i),
                {24'd0, CPOL, CPHA, transaction_length, division_ratio},
                (exp_g[i] == 2'b10) ? 32'hD5 : 32'h03);
            wait_done($sformatf("t2_done_seen%0d", i));
            chk($sformatf("t2_done%0d", i), {30'd0, done}, {30'd0, exp_g[i]});
            chk($sformatf("t2_cfg_end%0d", i),
                {24'd0, CPOL, CPHA, transaction_length, division_ratio},
                (exp_g[i] == 2'b10) ? 32'hD5 : 32'h03);
            chk($sformatf("t2_rx%0d", i), rx_out,
                (exp_g[i] == 2'b10) ? 32'h3C3C0F0F : 32'hA5A5A5A5);
            if (i == 3) req = 2'b00;
            tick();
            chk($sformatf("t2_idle_gap%0d", i), {30'd0, grant}, 32'd0);
            tick();
        end
        chk("t2_no_regrant", {30'd0, grant}, 32'd0);

        // Reset while the master is mid-transfer.
        req = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = busy && !start_trans && (grant != 2'b00);
        end
        chk("t3_in_wait", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b00;
        chk_all_zero("t3_reset");
        seen = 1'b0;
        for (int i = 0; i < 20 && busy; i++) begin
            tick();
            if (done != 2'b00) seen = 1'b1;
        end
        chk("t3_no_done", {31'd0, seen}, 32'd0);
        chk("t3_master_idle", {31'd0, busy}, 32'd0);
        req = 2'b11;
        tick();
        chk("t3_ptr_reset_grant", {30'd0, grant}, 32'h1);
        req = 2'b10;
        wait_done("t3_done_seen");
        chk("t3_done", {30'd0, done}, 32'h1);
        tick();
        tick();
        chk("t3_next_grant", {30'd0, grant}, 32'h2);
        req = 2'b00;
        wait_done("t3b_done_seen");
        tick();

        // Master busy before request: no grant until it clears.
        busy_hold = 1'b1;
        req = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        chk("t4_blocked", {30'd0, grant}, 32'd0);
        busy_hold = 1'b0;
        tick();
        chk("t4_grant", {30'd0, grant}, 32'h1);
        wait_done("t4_done_seen");
        chk("t4_rx", rx_out, 32'hA5A5A5A5);
        req = 2'b00;
        tick();

`ifdef SPI_ARB_TIMEOUT_EN
        // Master never answers: watchdog aborts on START cycle 16.
        model_en = 1'b0;
        req = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = start_trans;
        end
        chk("t5_start", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 14; i++) tick();
        chk("t5_early", {29'd0, done, err}, 32'd0);
        tick();
        chk("t5_done", {30'd0, done}, 32'h2);
        chk("t5_err", {31'd0, err}, 32'd1);
        chk("t5_rx_kept", rx_out, 32'hA5A5A5A5);
        req = 2'b00;
        tick();
        chk("t5_release", {29'd0, grant, err}, 32'd0);
        chk("t5_start_off", {31'd0, start_trans}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
